// File: rtl/uart_pkg.sv
// uart_pkg: shared encodings and defaults for the UART transmit arbiter.
// Holds the FSM state type, data width and the default timing constants.
package uart_pkg;

  localparam int UART_DATA_W      = 8;
  localparam int DEF_GAP_CYCLES   = 16;
  localparam int DEF_BUSY_TIMEOUT = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GAP       = 3'd4
  } state_e;

  // Bits needed to count 0..max_val, never less than one.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick of the next requester.
// Ports: req_i (request vector), ptr_i (last grant) -> gnt_o, idx_o, any_o.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o,
  output logic                       any_o
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);

  logic [IW-1:0] cand;

  // Scan ptr+1, ptr+2, ... with an explicit wrap so that
  // non-power-of-two requester counts never index past the end.
  always_comb begin
    cand  = ptr_i;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (cand == LAST) cand = '0;
      else              cand = cand + 1'b1;
      if (!any_o && req_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_o[i] = any_o && (idx_o == IW'(i));
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART_Tx among NUM_REQ producers.
// Ports: clk, rst (sync, active high); req_valid/req_data/req_ready per
// requester; tx_start/tx_data/tx_busy to UART_Tx; grant_id, active,
// err_timeout status.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           tx_start,
  output logic [UART_DATA_W-1:0]         tx_data,
  input  logic                           tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           active,
  output logic                           err_timeout
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = cnt_w(BUSY_TIMEOUT);
  localparam int GW = cnt_w(GAP_CYCLES);

  localparam logic [TW-1:0] TO_LAST  = TW'(BUSY_TIMEOUT);
  localparam logic [GW-1:0] GAP_LAST =
    (GAP_CYCLES == 0) ? '0 : GW'(GAP_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [IW-1:0]          ptr_q, ptr_d;
  logic [IW-1:0]          gid_q, gid_d;
  logic [UART_DATA_W-1:0] data_q, data_d;
  logic                   act_q, act_d;
  logic                   start_q, start_d;
  logic                   err_q, err_d;
  logic [TW-1:0]          tcnt_q, tcnt_d;
  logic [GW-1:0]          gcnt_q, gcnt_d;

  logic [NUM_REQ-1:0]     gnt;
  logic [IW-1:0]          sel_idx;
  logic                   sel_any;
  logic [UART_DATA_W-1:0] sel_data;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .req_i(req_valid),
    .ptr_i(ptr_q),
    .gnt_o(gnt),
    .idx_o(sel_idx),
    .any_o(sel_any)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == IW'(i))
        sel_data = req_data[i*UART_DATA_W +: UART_DATA_W];
    end
  end

  // Accept is Mealy from IDLE so the byte is latched on the same edge.
  assign req_ready   = (state_q == S_IDLE && !rst) ? gnt : '0;
  assign tx_start    = start_q;
  assign tx_data     = data_q;
  assign grant_id    = gid_q;
  assign active      = act_q;
  assign err_timeout = err_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    data_d  = data_q;
    act_d   = act_q;
    start_d = 1'b0;
    err_d   = 1'b0;
    tcnt_d  = tcnt_q;
    gcnt_d  = gcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (sel_any) begin
          data_d  = sel_data;
          gid_d   = sel_idx;
          ptr_d   = sel_idx;
          act_d   = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        start_d = 1'b1;
        tcnt_d  = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (tcnt_q == TO_LAST) begin
          err_d   = 1'b1;
          gcnt_d  = '0;
          state_d = S_GAP;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          gcnt_d  = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        // A zero gap still spends one cycle here.
        if (gcnt_q == GAP_LAST) begin
          act_d   = 1'b0;
          state_d = S_IDLE;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= IW'(NUM_REQ - 1);
      gid_q   <= '0;
      data_q  <= '0;
      act_q   <= 1'b0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      tcnt_q  <= '0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      data_q  <= data_d;
      act_q   <= act_d;
      start_q <= start_d;
      err_q   <= err_d;
      tcnt_q  <= tcnt_d;
      gcnt_q  <= gcnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for the UART transmit arbiter.
// dut0 uses the default gap, dut1 a zero gap; UART_Tx is a busy stub.
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int G0    = 16;
  localparam int G1    = 0;
  localparam int BT    = 8;
  localparam int FRAME = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid0, req_valid1;
  logic [31:0] req_data0, req_data1;
  logic [3:0]  req_ready0, req_ready1;
  logic        tx_start0, tx_start1;
  logic [7:0]  tx_data0, tx_data1;
  logic        busy0, busy1;
  logic [1:0]  grant_id0, grant_id1;
  logic        active0, active1;
  logic        err0, err1;

  int n_cmp = 0;
  int n_bad = 0;
  int n_grants = 0;
  int rdy_seen0 = 0;
  int rdy_seen1 = 0;
  int cyc = 0;
  int bcnt0 = 0;
  int bcnt1 = 0;
  bit dead0 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_arbiter #(
    .NUM_REQ(N), .GAP_CYCLES(G0), .BUSY_TIMEOUT(BT)
  ) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid0), .req_data(req_data0),
    .req_ready(req_ready0), .tx_start(tx_start0),
    .tx_data(tx_data0), .tx_busy(busy0),
    .grant_id(grant_id0), .active(active0),
    .err_timeout(err0)
  );

  uart_tx_arbiter #(
    .NUM_REQ(N), .GAP_CYCLES(G1), .BUSY_TIMEOUT(BT)
  ) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_data(req_data1),
    .req_ready(req_ready1), .tx_start(tx_start1),
    .tx_data(tx_data1), .tx_busy(busy1),
    .grant_id(grant_id1), .active(active1),
    .err_timeout(err1)
  );

  // UART_Tx stand-in: busy for FRAME cycles after a start; ignores rst.
  always @(posedge clk) begin
    if (bcnt0 != 0) bcnt0 <= bcnt0 - 1;
    else if (tx_start0 && !dead0) bcnt0 <= FRAME;
    if (bcnt1 != 0) bcnt1 <= bcnt1 - 1;
    else if (tx_start1) bcnt1 <= FRAME;
  end
  assign busy0 = (bcnt0 != 0);
  assign busy1 = (bcnt1 != 0);

  always begin
    @(negedge clk);
    #2;
    if (req_ready0 != 0) rdy_seen0++;
    if (req_ready1 != 0) rdy_seen1++;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  // Wait for a grant on dut0, check the handshake and start timing,
  // then optionally follow the frame through the gap.
  task automatic serve(input int idx, input logic [7:0] d,
                       input logic [3:0] clr, input bit full);
    bit ok;
    int n;
    #1;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (req_ready0 != 0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("ready_seen", 32'(ok), 1);
    if (!ok) return;
    chk("ready_onehot", 32'(req_ready0), 32'(1) << idx);
    n_grants++;
    @(negedge clk);
    req_valid0 = req_valid0 & ~clr;
    chk("tx_data_latch", 32'(tx_data0), 32'(d));
    chk("grant_id", 32'(grant_id0), idx);
    chk("active_on", 32'(active0), 1);
    chk("start_early", 32'(tx_start0), 0);
    @(negedge clk);
    chk("tx_start", 32'(tx_start0), 1);
    chk("tx_data_start", 32'(tx_data0), 32'(d));
    if (full) begin
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
        if (busy0) begin ok = 1'b1; break; end
        @(negedge clk);
      end
      chk("busy_rise", 32'(ok), 1);
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if (!busy0) begin ok = 1'b1; break; end
      end
      chk("busy_fall", 32'(ok), 1);
      n = 0;
      while (active0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("gap_len", n, G0 + 1);
    end
  endtask

  typedef struct {
    logic [3:0] mask;
    int         exp_idx;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int n;
    int prev;
    bit ok;

    tbl[0]  = '{4'b0001, 0, 8'h41};
    tbl[1]  = '{4'b1111, 1, 8'h42};
    tbl[2]  = '{4'b1111, 2, 8'h43};
    tbl[3]  = '{4'b1111, 3, 8'h44};
    tbl[4]  = '{4'b1111, 0, 8'h41};
    tbl[5]  = '{4'b1010, 1, 8'h42};
    tbl[6]  = '{4'b1010, 3, 8'h44};
    tbl[7]  = '{4'b0100, 2, 8'h43};
    tbl[8]  = '{4'b1001, 3, 8'h44};
    tbl[9]  = '{4'b1001, 0, 8'h41};
    tbl[10] = '{4'b0110, 1, 8'h42};
    tbl[11] = '{4'b0001, 0, 8'h41};

    req_valid0 = '0;
    req_valid1 = '0;
    req_data0  = {8'h44, 8'h43, 8'h42, 8'h41};
    req_data1  = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready0), 0);
    chk("rst_start", 32'(tx_start0), 0);
    chk("rst_data", 32'(tx_data0), 0);
    chk("rst_gid", 32'(grant_id0), 0);
    chk("rst_active", 32'(active0), 0);
    chk("rst_err", 32'(err0), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      req_valid0 = tbl[i].mask;
      serve(tbl[i].exp_idx, tbl[i].exp_data, 4'hF, 1'b1);
    end

    // Fairness: req0 never drops, req2 arrives after the first grant.
    req_data0[7:0]   = 8'h55;
    req_data0[23:16] = 8'hAA;
    req_valid0 = 4'b0001;
    serve(0, 8'h55, 4'b0000, 1'b1);
    req_valid0[2] = 1'b1;
    serve(2, 8'hAA, 4'b0100, 1'b1);
    serve(0, 8'h55, 4'b0001, 1'b1);

    // Timeout: the stub never raises busy.
    req_data0 = {8'h44, 8'h43, 8'h42, 8'h41};
    dead0 = 1'b1;
    req_valid0 = 4'b0010;
    serve(1, 8'h42, 4'hF, 1'b0);
    n = 0;
    while (!err0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_lat", n, BT + 1);
    @(negedge clk);
    chk("timeout_pulse", 32'(err0), 0);
    n = 0;
    while (active0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_idle", 32'(active0), 0);
    dead0 = 1'b0;
    req_valid0 = 4'b1000;
    serve(3, 8'h44, 4'hF, 1'b1);

    // Reset while the frame is in WAIT_DONE with req1 pending.
    req_valid0 = 4'b0100;
    serve(2, 8'h43, 4'hF, 1'b0);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (busy0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("mid_busy", 32'(ok), 1);
    @(negedge clk);
    req_valid0 = 4'b0010;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_ready", 32'(req_ready0), 0);
    chk("mid_start", 32'(tx_start0), 0);
    chk("mid_data", 32'(tx_data0), 0);
    chk("mid_gid", 32'(grant_id0), 0);
    chk("mid_active", 32'(active0), 0);
    chk("mid_err", 32'(err0), 0);
    req_valid0 = 4'b0011;
    for (int k = 0; k < 20 && busy0; k++) begin
      @(negedge clk);
      chk("mid_hold_ready", 32'(req_ready0), 0);
    end
    @(negedge clk);
    chk("mid_hold_ready", 32'(req_ready0), 0);
    rst = 1'b0;
    serve(0, 8'h41, 4'b0001, 1'b1);
    serve(1, 8'h42, 4'b0010, 1'b1);

    // Zero gap, req0 always valid: start spacing is the start cycle,
    // FRAME busy cycles, the busy-low sample, then GAP, IDLE, START.
    req_data1  = 32'h60;
    req_valid1 = 4'b0001;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      ok = 1'b0;
      for (int j = 0; j < 100; j++) begin
        @(negedge clk);
        if (tx_start1) begin ok = 1'b1; break; end
      end
      chk("g0_start", 32'(ok), 1);
      chk("g0_data", 32'(tx_data1), 32'h60 + k);
      if (k > 0) chk("g0_spacing", cyc - prev, FRAME + 5);
      prev = cyc;
      req_data1[7:0] = 8'(8'h61 + k);
    end
    req_valid1 = '0;
    repeat (30) @(negedge clk);

    chk("ready_pulses0", rdy_seen0, n_grants);
    chk("ready_pulses1", rdy_seen1, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish by %0d",
             cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
